// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one single-port synchronous memory between two masters
//            (port 0 = CPU, port 1 = debug/loader). Each access is a
//            two-cycle ISSUE/CAPT transaction; simultaneous requests are
//            resolved round-robin (FIXED_PRIO=0) or port-0-first (FIXED_PRIO=1).
// Ports    : clk, rst_n            - clock (rising edge), async active-low reset
//            req/we/addr/wdata<n>  - port n request, held stable until ack<n>
//            ack<n>                - one-cycle completion pulse for port n
//            rdata<n>              - port n read data, valid with ack<n>, held
//            mem_we/addr/data      - memory write enable, address, write data
//            mem_in                - memory read data (one cycle after address)
//            busy                  - high during ISSUE and CAPT
//            grant                 - port owning the current/last transaction
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16,
    parameter int FIXED_PRIO = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    output logic                  ack0,
    output logic [DATA_WIDTH-1:0] rdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ack1,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    input  logic [DATA_WIDTH-1:0] mem_in,
    output logic                  busy,
    output logic                  grant
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_CAPT  = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_last;      // port served by the most recent completed transaction
    logic                  r_is_write;  // current transaction is a write
    logic [DATA_WIDTH-1:0] r_rdata0;
    logic [DATA_WIDTH-1:0] r_rdata1;

    logic w_arb_state;
    logic w_elig0;
    logic w_elig1;
    logic w_any;
    logic w_win;

    // The port being acked in CAPT is excluded so a requester that only drops
    // req after seeing ack is not served twice.
    always_comb begin
        w_arb_state = (r_state == S_IDLE) || (r_state == S_CAPT);
        w_elig0     = req0 && !((r_state == S_CAPT) && (grant == 1'b0));
        w_elig1     = req1 && !((r_state == S_CAPT) && (grant == 1'b1));
        w_any       = w_arb_state && (w_elig0 || w_elig1);
        w_win       = 1'b0;
        if (w_elig0 && w_elig1) begin
            w_win = (FIXED_PRIO != 0) ? 1'b0 : ~r_last;
        end else begin
            w_win = w_elig1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_last     <= 1'b1;
            r_is_write <= 1'b0;
            r_rdata0   <= '0;
            r_rdata1   <= '0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= '0;
            busy       <= 1'b0;
            grant      <= 1'b1;
        end else begin
            ack0   <= 1'b0;
            ack1   <= 1'b0;
            mem_we <= 1'b0;
            case (r_state)
                S_IDLE, S_CAPT: begin
                    if (r_state == S_CAPT) begin
                        // mem_in holds the word addressed during ISSUE
                        if (!r_is_write) begin
                            if (grant) r_rdata1 <= mem_in;
                            else       r_rdata0 <= mem_in;
                        end
                        r_last <= grant;
                    end
                    if (w_any) begin
                        r_state    <= S_ISSUE;
                        grant      <= w_win;
                        busy       <= 1'b1;
                        mem_addr   <= w_win ? addr1  : addr0;
                        mem_data   <= w_win ? wdata1 : wdata0;
                        mem_we     <= w_win ? we1    : we0;
                        r_is_write <= w_win ? we1    : we0;
                    end else begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    r_state <= S_CAPT;
                    if (grant) ack1 <= 1'b1;
                    else       ack0 <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Read data is forwarded straight from memory while the ack is high so it
    // is valid in the same cycle as the ack, then held from the register.
    assign rdata0 = (ack0 && !r_is_write) ? mem_in : r_rdata0;
    assign rdata1 = (ack1 && !r_is_write) ? mem_in : r_rdata1;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Directed self-checking bench for mem_arbiter. A round-robin and
//            a fixed-priority instance share stimulus; each has its own
//            synchronous memory model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    localparam int AW = 6;
    localparam int DW = 16;

    logic          clk;
    logic          rst_n;
    logic          req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;

    logic          rr_ack0, rr_ack1, rr_mem_we, rr_busy, rr_grant;
    logic [DW-1:0] rr_rdata0, rr_rdata1, rr_mem_data, rr_mem_in;
    logic [AW-1:0] rr_mem_addr;

    logic          fp_ack0, fp_ack1, fp_mem_we, fp_busy, fp_grant;
    logic [DW-1:0] fp_rdata0, fp_rdata1, fp_mem_data, fp_mem_in;
    logic [AW-1:0] fp_mem_addr;

    // backdoor preload of both memories
    logic          bd_we;
    logic [AW-1:0] bd_addr;
    logic [DW-1:0] bd_data;

    logic [DW-1:0] rr_mem [0:(1<<AW)-1];
    logic [DW-1:0] fp_mem [0:(1<<AW)-1];

    int checks   = 0;
    int failures = 0;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIO(0)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .ack0(rr_ack0), .rdata0(rr_rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .ack1(rr_ack1), .rdata1(rr_rdata1),
        .mem_we(rr_mem_we), .mem_addr(rr_mem_addr), .mem_data(rr_mem_data),
        .mem_in(rr_mem_in), .busy(rr_busy), .grant(rr_grant)
    );

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIO(1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .ack0(fp_ack0), .rdata0(fp_rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .ack1(fp_ack1), .rdata1(fp_rdata1),
        .mem_we(fp_mem_we), .mem_addr(fp_mem_addr), .mem_data(fp_mem_data),
        .mem_in(fp_mem_in), .busy(fp_busy), .grant(fp_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // synchronous read-first memories: data appears the cycle after the address
    always @(posedge clk) begin
        if (bd_we) begin
            rr_mem[bd_addr] <= bd_data;
            fp_mem[bd_addr] <= bd_data;
        end else begin
            if (rr_mem_we) rr_mem[rr_mem_addr] <= rr_mem_data;
            if (fp_mem_we) fp_mem[fp_mem_addr] <= fp_mem_data;
        end
        rr_mem_in <= rr_mem[rr_mem_addr];
        fp_mem_in <= fp_mem[fp_mem_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        for (int i = 0; i < (1<<AW); i++) begin
            rr_mem[i] = '0;
            fp_mem[i] = '0;
        end

        // preload while in reset
        tick();
        bd_we = 1'b1; bd_addr = 6'd5;  bd_data = 16'h1234;
        tick();
        bd_addr = 6'd20; bd_data = 16'h00AA;
        tick();
        bd_we = 1'b0;
        tick();

        // reset state
        chk("rst_mem_we",   rr_mem_we,   1'b0);
        chk("rst_mem_addr", rr_mem_addr, 6'd0);
        chk("rst_mem_data", rr_mem_data, 16'h0);
        chk("rst_acks",     {rr_ack0, rr_ack1}, 2'b00);
        chk("rst_rdata0",   rr_rdata0,   16'h0);
        chk("rst_rdata1",   rr_rdata1,   16'h0);
        chk("rst_busy",     rr_busy,     1'b0);
        chk("rst_grant",    rr_grant,    1'b1);
        rst_n = 1'b1;
        tick();

        // reset asserted in the middle of a write ISSUE
        req0 = 1'b1; we0 = 1'b1; addr0 = 6'd10; wdata0 = 16'hAAAA;
        tick();
        chk("t1_issue_we",    rr_mem_we,   1'b1);
        chk("t1_issue_grant", rr_grant,    1'b0);
        chk("t1_issue_addr",  rr_mem_addr, 6'd10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t1_async_we",    rr_mem_we,   1'b0);
        chk("t1_async_busy",  rr_busy,     1'b0);
        chk("t1_async_grant", rr_grant,    1'b1);
        chk("t1_async_addr",  rr_mem_addr, 6'd0);
        req0 = 1'b0; we0 = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t1_no_ack", {rr_ack0, rr_ack1, rr_busy}, 3'b000);
        end

        // single read by port 0
        req0 = 1'b1; we0 = 1'b0; addr0 = 6'd5;
        tick();
        chk("t2_issue_addr", rr_mem_addr, 6'd5);
        chk("t2_issue_we",   rr_mem_we,   1'b0);
        chk("t2_issue_ack",  {rr_ack0, rr_ack1}, 2'b00);
        chk("t2_issue_busy", rr_busy,     1'b1);
        tick();
        chk("t2_capt_ack",   {rr_ack0, rr_ack1}, 2'b10);
        chk("t2_rdata0",     rr_rdata0,   16'h1234);
        req0 = 1'b0;
        tick();
        chk("t2_idle",       {rr_ack0, rr_busy}, 2'b00);
        chk("t2_rdata0_hold", rr_rdata0,  16'h1234);

        // port 1 writes top address, then reads it back
        req1 = 1'b1; we1 = 1'b1; addr1 = 6'd63; wdata1 = 16'hBEEF;
        tick();
        chk("t3_w_issue_we",   rr_mem_we,   1'b1);
        chk("t3_w_issue_addr", rr_mem_addr, 6'd63);
        chk("t3_w_issue_data", rr_mem_data, 16'hBEEF);
        chk("t3_w_grant",      rr_grant,    1'b1);
        tick();
        chk("t3_w_capt_we",    rr_mem_we,   1'b0);
        chk("t3_w_ack",        {rr_ack0, rr_ack1}, 2'b01);
        chk("t3_w_rdata1",     rr_rdata1,   16'h0);
        we1 = 1'b0;
        tick();
        chk("t3_idle_we",      {rr_mem_we, rr_ack1}, 2'b00);
        tick();
        chk("t3_r_issue_we",   rr_mem_we,   1'b0);
        chk("t3_r_issue_addr", rr_mem_addr, 6'd63);
        tick();
        chk("t3_r_ack",        {rr_ack0, rr_ack1}, 2'b01);
        chk("t3_rdata1",       rr_rdata1,   16'hBEEF);
        req1 = 1'b0;
        tick();

        // round-robin with both ports held
        req0 = 1'b1; we0 = 1'b0; addr0 = 6'd5;
        req1 = 1'b1; we1 = 1'b0; addr1 = 6'd63;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i % 2 == 0) begin
                chk("t4_grant", rr_grant, ((i / 2) % 2 == 1) ? 1'b1 : 1'b0);
                chk("t4_issue_noack", {rr_ack0, rr_ack1}, 2'b00);
            end else begin
                chk("t4_acks", {rr_ack0, rr_ack1}, ((i / 2) % 2 == 0) ? 2'b10 : 2'b01);
                if ((i / 2) % 2 == 0) chk("t4_rdata0", rr_rdata0, 16'h1234);
                else                  chk("t4_rdata1", rr_rdata1, 16'hBEEF);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();
        chk("t4_idle", rr_busy, 1'b0);

        // read hold: port 1 write must not disturb port 0 read data
        req0 = 1'b1; we0 = 1'b0; addr0 = 6'd20;
        tick();
        tick();
        chk("t6_ack0",   rr_ack0,   1'b1);
        chk("t6_rdata0", rr_rdata0, 16'h00AA);
        req0 = 1'b0;
        req1 = 1'b1; we1 = 1'b1; addr1 = 6'd20; wdata1 = 16'h5555;
        tick();
        chk("t6_w_issue", {rr_mem_we, rr_grant}, 2'b11);
        tick();
        chk("t6_w_ack",   rr_ack1,   1'b1);
        chk("t6_hold_a",  rr_rdata0, 16'h00AA);
        we1 = 1'b0;
        tick();
        tick();
        tick();
        chk("t6_r_ack",   rr_ack1,   1'b1);
        chk("t6_rdata1",  rr_rdata1, 16'h5555);
        chk("t6_hold_b",  rr_rdata0, 16'h00AA);
        req1 = 1'b0;
        tick();

        // fixed priority versus round-robin on a tie after port 0 was last served
        req0 = 1'b1; we0 = 1'b0; addr0 = 6'd5;
        tick();
        tick();
        req0 = 1'b0;
        tick();
        req0 = 1'b1; req1 = 1'b1; we1 = 1'b0; addr1 = 6'd20;
        tick();
        chk("t5_rr_grant", rr_grant, 1'b1);
        chk("t5_fp_grant", fp_grant, 1'b0);
        tick();
        chk("t5_rr_ack",    {rr_ack0, rr_ack1}, 2'b01);
        chk("t5_fp_ack",    {fp_ack0, fp_ack1}, 2'b10);
        chk("t5_fp_rdata0", fp_rdata0, 16'h1234);
        req0 = 1'b0;
        tick();
        chk("t5_fp_grant1", {fp_grant, fp_busy}, 2'b11);
        tick();
        chk("t5_fp_ack1",   {fp_ack0, fp_ack1}, 2'b01);
        chk("t5_fp_rdata1", fp_rdata1, 16'h5555);
        req1 = 1'b0;
        tick();
        tick();
        tick();
        chk("t5_settle", {rr_busy, fp_busy}, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
